// File: rtl/program_loader_pkg.sv
// Shared types and frame constants for the program loader and its benches.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
  localparam logic [31:0] HALT_INSN = 32'h0000_007F;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface program_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // slave is the loader; master is the byte source / memory observer
  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Collects little-endian bytes into 32-bit words; the 4th byte is passed
// straight through so the word is available in the cycle it arrives.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int LANES = BYTES_PER_WORD - 1;

  logic [1:0]             byte_idx;
  logic [LANES-1:0][7:0]  lanes;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] lane_q;
    always_ff @(posedge clk) begin
      if (!rst_n || clear)
        lane_q <= 8'h00;
      else if (strobe && byte_idx == 2'(g))
        lane_q <= byte_in;
    end
    assign lanes[g] = lane_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear)
      byte_idx <= 2'd0;
    else if (strobe)
      byte_idx <= byte_idx + 2'd1;
  end

  assign word       = {byte_in, lanes[2], lanes[1], lanes[0]};
  assign word_valid = strobe && (byte_idx == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Loads a checksummed byte-stream program image into instruction memory and
// releases the processor halt only after a fully verified load.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  program_loader_if.slave   bus,
  output logic              hlt,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  state_e          state;
  logic [7:0]      len_lo;
  logic [15:0]     len;
  logic [ADDR_W:0] word_idx;
  logic [7:0]      csum;

  logic        xfer;
  logic        restart;
  logic [31:0] wa_word;
  logic        wa_valid;

  assign xfer    = bus.in_valid && bus.in_ready;
  assign restart = start && (state == IDLE || state == ERROR);

  word_assembler u_wa (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (restart),
    .strobe     (xfer && state == DATA),
    .byte_in    (bus.in_data),
    .word       (wa_word),
    .word_valid (wa_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      hlt            <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      words_loaded   <= '0;
      len_lo         <= '0;
      len            <= '0;
      word_idx       <= '0;
      csum           <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE, ERROR: begin
          if (start) begin
            state        <= LEN_LO;
            bus.in_ready <= 1'b1;
            error        <= 1'b0;
            hlt          <= 1'b1;
            words_loaded <= '0;
            csum         <= '0;
            word_idx     <= '0;
            len          <= '0;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len_lo <= bus.in_data;
            csum   <= csum ^ bus.in_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len  <= {bus.in_data, len_lo};
            csum <= csum ^ bus.in_data;
            if ({bus.in_data, len_lo} > 16'(DEPTH)) begin
              state        <= ERROR;
              bus.in_ready <= 1'b0;
              error        <= 1'b1;
              hlt          <= 1'b1;
            end else if ({bus.in_data, len_lo} == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            csum <= csum ^ bus.in_data;
            if (wa_valid) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_idx[ADDR_W-1:0];
              bus.imem_wdata <= wa_word;
              words_loaded   <= word_idx + 1'b1;
              word_idx       <= word_idx + 1'b1;
              if (16'(word_idx) + 16'd1 == len)
                state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == csum) begin
              state <= DONE;
              done  <= 1'b1;
              hlt   <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
              hlt   <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized frame loads checked against a frame-level reference model.
module tb_program_loader;
  import loader_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic hlt, done, error;
  logic [ADDR_W:0] words_loaded;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .hlt          (hlt),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [ADDR_W+31:0] wq[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_we) wq.push_back({bus.imem_addr, bus.imem_wdata});
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Drives up to nmax bytes; a byte counts as sent when valid is up while
  // ready (registered, so stable from negedge to the next posedge) is high.
  task automatic send(input logic [7:0] q[$], input bit gaps, input bit mid_start, input int nmax);
    int i = 0;
    int cyc = 0;
    while (i < nmax && cyc < nmax * 4 + 20) begin
      @(negedge clk);
      cyc++;
      start        = mid_start && (i == 4);
      bus.in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      bus.in_data  = q[i];
      if (bus.in_valid && bus.in_ready) i++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    start        = 1'b0;
    if (i < nmax) chk("send_timeout", 64'(i), 64'(nmax));
  endtask

  function automatic void make_frame(input int n, input bit bad_csum, output logic [7:0] q[$]);
    logic [7:0] x;
    q = {};
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    for (int i = 0; i < n * 4; i++) q.push_back(8'($urandom));
    x = 8'h00;
    foreach (q[i]) x ^= q[i];
    q.push_back(bad_csum ? x ^ 8'($urandom_range(1, 255)) : x);
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] q[$]);
    int n;
    bit ovs, ok;
    int nw;
    logic [7:0] x;
    n   = {q[1], q[0]};
    ovs = n > DEPTH;
    x   = 8'h00;
    for (int i = 0; i < q.size() - 1; i++) x ^= q[i];
    ok  = !ovs && (x == q[q.size()-1]);
    nw  = ovs ? 0 : n;
    chk({tag, "_nwr"}, 64'(wq.size()), 64'(nw));
    for (int i = 0; i < nw && i < wq.size(); i++)
      chk({tag, "_wr"}, 64'(wq[i]),
          64'({ADDR_W'(i), q[2+4*i+3], q[2+4*i+2], q[2+4*i+1], q[2+4*i]}));
    chk({tag, "_done"}, 64'(done_cnt), 64'(ok));
    chk({tag, "_err"},  64'(error), 64'(!ok));
    chk({tag, "_hlt"},  64'(hlt), 64'(!ok));
    chk({tag, "_wl"},   64'(words_loaded), 64'(nw));
    chk({tag, "_rdy"},  64'(bus.in_ready), 64'd0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] q[$], input bit gaps, input bit mid);
    wq.delete();
    done_cnt = 0;
    pulse_start();
    send(q, gaps, mid, q.size());
    repeat (4) @(negedge clk);
    check_frame(tag, q);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"},   64'(bus.in_ready), 64'd0);
    chk({tag, "_we"},    64'(bus.imem_we), 64'd0);
    chk({tag, "_addr"},  64'(bus.imem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
    chk({tag, "_hlt"},   64'(hlt), 64'd1);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_err"},   64'(error), 64'd0);
    chk({tag, "_wl"},    64'(words_loaded), 64'd0);
  endtask

  initial begin
    logic [7:0] nom[$];
    logic [7:0] q[$];
    int nwr;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    nom = {8'h02, 8'h00, 8'h13, 8'h05, 8'hC0, 8'h00, 8'hEF, 8'h00, 8'h00, 8'h01, 8'h3A};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("nominal", nom, 1'b0, 1'b0);
    chk("nominal_w0", 64'(wq.size() > 0 ? wq[0] : '0), 64'({6'd0, 32'h00C00513}));

    q = {8'h00, 8'h00, 8'h00};
    run_frame("zero", q, 1'b0, 1'b0);

    q = {8'h41, 8'h00};
    run_frame("oversize", q, 1'b0, 1'b0);
    run_frame("recover", nom, 1'b0, 1'b0);

    q = nom;
    q[10] = 8'h3B;
    run_frame("badcsum", q, 1'b0, 1'b0);

    run_frame("gaps", nom, 1'b1, 1'b1);

    // Reset after 6 bytes: one word has been written, nothing afterwards.
    wq.delete();
    pulse_start();
    send(nom, 1'b0, 1'b0, 6);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("midreset");
    nwr = wq.size();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    repeat (10) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("midreset_nowr", 64'(wq.size()), 64'(nwr));
    chk("midreset_hlt", 64'(hlt), 64'd1);
    run_frame("postreset", nom, 1'b0, 1'b0);

    for (int it = 0; it < 20; it++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 2) begin
        int n;
        n = $urandom_range(DEPTH + 1, 300);
        q = {8'(n), 8'(n >> 8)};
      end else begin
        make_frame($urandom_range(0, 6), kind == 1, q);
      end
      run_frame("rand", q, 1'($urandom_range(0, 1)), kind == 3);
    end

    // Boundary: a full-depth image fills every address.
    make_frame(DEPTH, 1'b0, q);
    run_frame("full", q, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
